// File: rtl/sonar_ping_sequencer.sv
// rtl/sonar_ping_sequencer.sv - one-ping clear/transmit/blank/listen sequencer with per-channel time of flight
module sonar_ping_sequencer #(
    parameter int N_CH    = 8,
    parameter int TW      = 16,
    parameter int CLR_CYC = 4
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic                 ce_pcm,
    input  logic [TW-1:0]        tx_len_i,
    input  logic [TW-1:0]        blank_i,
    input  logic [TW-1:0]        timeout_i,
    input  logic [N_CH-1:0]      cmp_i,
    output logic                 mclear_o,
    output logic                 tx_en_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [N_CH-1:0]      hit_o,
    output logic [N_CH*TW-1:0]   tof_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_TX,
        S_BLANK,
        S_LISTEN,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [TW-1:0]       r_timer;
    logic [TW-1:0]       r_tx_len;
    logic [TW-1:0]       r_blank;
    logic [TW-1:0]       r_timeout;
    logic [3:0]          r_clr_cnt;
    logic                r_mclear;
    logic                r_tx_en;
    logic                r_busy;
    logic                r_done;
    logic [N_CH-1:0]     r_hit;
    logic [N_CH*TW-1:0]  r_tof;

    logic [TW-1:0]       w_timer_next;
    logic [TW:0]         w_timer_p1;
    logic                w_tx_last;
    logic [N_CH-1:0]     w_new_hit;
    logic                w_all_hit;
    logic                w_listen_exit;

    // Timer step (saturating) and the exit decisions for each timed phase
    always_comb begin
        w_timer_next  = (ce_pcm && !(&r_timer)) ? r_timer + {{(TW-1){1'b0}}, 1'b1} : r_timer;
        w_timer_p1    = {1'b0, r_timer} + {{TW{1'b0}}, 1'b1};
        w_tx_last     = (r_tx_len == '0) || (ce_pcm && (w_timer_p1 >= {1'b0, r_tx_len}));
        w_new_hit     = cmp_i & ~r_hit;
        w_all_hit     = &(r_hit | cmp_i);
        w_listen_exit = w_all_hit || (r_timer >= r_timeout);
    end

    // Ping state machine with registered outputs; abort beats everything except reset
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_tx_len  <= '0;
            r_blank   <= '0;
            r_timeout <= '0;
            r_clr_cnt <= '0;
            r_mclear  <= 1'b0;
            r_tx_en   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hit     <= '0;
            r_tof     <= '0;
        end else if (abort_i && (r_state != S_IDLE)) begin
            r_state  <= S_IDLE;
            r_mclear <= 1'b0;
            r_tx_en  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start_i && !abort_i) begin
                        r_state   <= S_CLEAR;
                        r_tx_len  <= tx_len_i;
                        r_blank   <= blank_i;
                        r_timeout <= timeout_i;
                        r_clr_cnt <= '0;
                        r_timer   <= '0;
                        r_hit     <= '0;
                        r_tof     <= '0;
                        r_mclear  <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (r_clr_cnt == 4'(CLR_CYC - 1)) begin
                        r_state  <= S_TX;
                        r_mclear <= 1'b0;
                        r_tx_en  <= 1'b1;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 4'd1;
                    end
                end
                S_TX: begin
                    r_timer <= w_timer_next;
                    if (w_tx_last) begin
                        r_state <= S_BLANK;
                        r_tx_en <= 1'b0;
                    end
                end
                S_BLANK: begin
                    r_timer <= w_timer_next;
                    if (r_timer >= r_blank) begin
                        r_state <= S_LISTEN;
                    end
                end
                S_LISTEN: begin
                    r_timer <= w_timer_next;
                    r_hit   <= r_hit | cmp_i;
                    for (int i = 0; i < N_CH; i++) begin
                        if (w_new_hit[i]) begin
                            r_tof[i*TW +: TW] <= r_timer;
                        end
                    end
                    if (w_listen_exit) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_mclear <= 1'b0;
                    r_tx_en  <= 1'b0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                end
            endcase
        end
    end

    assign mclear_o = r_mclear;
    assign tx_en_o  = r_tx_en;
    assign busy_o   = r_busy;
    assign done_o   = r_done;
    assign hit_o    = r_hit;
    assign tof_o    = r_tof;

endmodule

// File: tb/tb_sonar_ping_sequencer.sv
// tb/tb_sonar_ping_sequencer.sv - directed self-checking bench for sonar_ping_sequencer
module tb_sonar_ping_sequencer;

    localparam int N_CH    = 8;
    localparam int TW      = 16;
    localparam int CLR_CYC = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                start_i;
    logic                abort_i;
    logic                ce_pcm;
    logic [TW-1:0]       tx_len_i;
    logic [TW-1:0]       blank_i;
    logic [TW-1:0]       timeout_i;
    logic [N_CH-1:0]     cmp_i;
    logic                mclear_o;
    logic                tx_en_o;
    logic                busy_o;
    logic                done_o;
    logic [N_CH-1:0]     hit_o;
    logic [N_CH*TW-1:0]  tof_o;

    int n_assert = 0;
    int n_fail   = 0;

    int rise_t[N_CH];
    int t;
    int done_t;
    int done_age;
    int done_k;
    int tx_ticks;
    int tx_cyc;
    bit done_seen;
    bit aborted;
    bit any_done;

    always #5 clk = ~clk;

    sonar_ping_sequencer #(
        .N_CH    (N_CH),
        .TW      (TW),
        .CLR_CYC (CLR_CYC)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .start_i   (start_i),
        .abort_i   (abort_i),
        .ce_pcm    (ce_pcm),
        .tx_len_i  (tx_len_i),
        .blank_i   (blank_i),
        .timeout_i (timeout_i),
        .cmp_i     (cmp_i),
        .mclear_o  (mclear_o),
        .tx_en_o   (tx_en_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .hit_o     (hit_o),
        .tof_o     (tof_o)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [TW-1:0] tof(input int i);
        return tof_o[i*TW +: TW];
    endfunction

    task automatic no_rise();
        for (int c = 0; c < N_CH; c++) rise_t[c] = -1;
    endtask

    // Issue start, scramble config inputs, then walk through the clear phase into TX
    task automatic start_ping(input logic [TW-1:0] tx, input logic [TW-1:0] bl, input logic [TW-1:0] to);
        tx_len_i  = tx;
        blank_i   = bl;
        timeout_i = to;
        start_i   = 1'b1;
        step();
        start_i   = 1'b0;
        tx_len_i  = 16'hFFFF;
        blank_i   = 16'hFFFF;
        timeout_i = 16'h0000;
        chk("clear_mclear_first", mclear_o, 1'b1);
        chk("clear_busy", busy_o, 1'b1);
        chk("clear_hit_zero", hit_o, '0);
        chk("clear_tof_zero", tof_o, '0);
        chk("clear_tx_en_low", tx_en_o, 1'b0);
        for (int i = 1; i < CLR_CYC; i++) begin
            step();
            chk("clear_mclear_hold", mclear_o, 1'b1);
        end
        step();
        chk("tx_mclear_low", mclear_o, 1'b0);
        chk("tx_en_high", tx_en_o, 1'b1);
    endtask

    // Drive ce with the given period and cmp from the bench's own tick count until done or abort
    task automatic run_ping(input int ce_per, input int abort_at, input int mid_start_at);
        int  age;
        int  pre_t;
        int  pre_age;
        logic ce;
        t = 0; age = 0;
        done_seen = 0; aborted = 0;
        done_t = -1; done_age = -1; done_k = -1;
        tx_ticks = 0; tx_cyc = 0;
        for (int k = 0; k < 70000 && !done_seen && !aborted; k++) begin
            ce = (ce_per != 0) && ((k % ce_per) == 0);
            for (int c = 0; c < N_CH; c++) cmp_i[c] = (rise_t[c] >= 0) && (t >= rise_t[c]);
            abort_i = (abort_at >= 0) && (t == abort_at) && (age == 0);
            start_i = (mid_start_at >= 0) && (t == mid_start_at) && (age == 0);
            ce_pcm  = ce;
            if (tx_en_o) tx_cyc++;
            if (ce && tx_en_o) tx_ticks++;
            pre_t   = t;
            pre_age = age;
            step();
            if (ce && t != 65535) begin
                t++;
                age = 0;
            end else begin
                age++;
            end
            if (abort_i) aborted = 1;
            if (done_o) begin
                done_seen = 1;
                done_t    = pre_t;
                done_age  = pre_age;
                done_k    = k + 1;
            end
        end
        abort_i = 1'b0;
        start_i = 1'b0;
        ce_pcm  = 1'b0;
    endtask

    task automatic after_done();
        step();
        chk("done_one_cycle", done_o, 1'b0);
        chk("idle_after_done", busy_o, 1'b0);
    endtask

    // Directed sequence of pings
    initial begin
        rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; ce_pcm = 1'b0;
        tx_len_i = '0; blank_i = '0; timeout_i = '0; cmp_i = '0;
        no_rise();
        step();
        step();
        rst = 1'b0;
        chk("rst_mclear", mclear_o, 1'b0);
        chk("rst_tx_en", tx_en_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_hit", hit_o, '0);
        chk("rst_tof", tof_o, '0);

        // Basic ping
        no_rise();
        rise_t[2] = 37;
        rise_t[5] = 50;
        start_ping(16'd3, 16'd10, 16'd100);
        run_ping(4, -1, -1);
        chk("basic_tx_ticks", tx_ticks, 3);
        chk("basic_done_seen", done_seen, 1'b1);
        chk("basic_done_t", done_t, 100);
        chk("basic_done_age", done_age, 0);
        chk("basic_hit", hit_o, 8'h24);
        chk("basic_tof2", tof(2), 16'd37);
        chk("basic_tof5", tof(5), 16'd50);
        chk("basic_tof0", tof(0), 16'd0);
        after_done();
        cmp_i = '0;

        // Blanking masks an early level
        no_rise();
        rise_t[0] = 0;
        cmp_i = 8'h01;
        start_ping(16'd2, 16'd20, 16'd40);
        run_ping(4, -1, -1);
        chk("blank_tof0", tof(0), 16'd20);
        chk("blank_hit", hit_o, 8'h01);
        chk("blank_done_t", done_t, 40);
        after_done();
        cmp_i = '0;

        // All channels hit together
        for (int c = 0; c < N_CH; c++) rise_t[c] = 15;
        start_ping(16'd1, 16'd5, 16'd1000);
        run_ping(4, -1, -1);
        chk("allhit_hit", hit_o, 8'hFF);
        for (int c = 0; c < N_CH; c++) chk("allhit_tof", tof(c), 16'd15);
        chk("allhit_done_t", done_t, 15);
        chk("allhit_done_age", done_age, 0);
        after_done();
        cmp_i = '0;

        // Reset during TX
        no_rise();
        start_ping(16'd50, 16'd60, 16'd70);
        ce_pcm = 1'b1;
        step();
        ce_pcm = 1'b0;
        step();
        chk("tx_busy_before_rst", busy_o, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_outputs", {mclear_o, tx_en_o, busy_o, done_o, hit_o}, '0);
        chk("midrst_tof", tof_o, '0);
        step();
        chk("midrst_stays_idle", busy_o, 1'b0);

        // Abort in LISTEN keeps partial results
        no_rise();
        rise_t[0] = 12;
        start_ping(16'd2, 16'd5, 16'd200);
        run_ping(4, 30, -1);
        cmp_i = '0;
        chk("abort_seen", aborted, 1'b1);
        chk("abort_busy", busy_o, 1'b0);
        chk("abort_tx_en", tx_en_o, 1'b0);
        chk("abort_mclear", mclear_o, 1'b0);
        chk("abort_no_done", done_o | done_seen, 1'b0);
        chk("abort_hit", hit_o, 8'h01);
        chk("abort_tof0", tof(0), 16'd12);
        any_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            any_done = any_done | done_o;
        end
        chk("abort_no_late_done", any_done, 1'b0);

        // Abort wins over start in IDLE
        start_i = 1'b1;
        abort_i = 1'b1;
        step();
        start_i = 1'b0;
        abort_i = 1'b0;
        chk("abort_beats_start", busy_o, 1'b0);
        chk("abort_beats_start_hit", hit_o, 8'h01);

        // Minimal configuration; new start clears previous partial results
        no_rise();
        rise_t[3] = 0;
        start_ping(16'd0, 16'd0, 16'd0);
        run_ping(0, -1, -1);
        chk("edge_tx_cycles", tx_cyc, 1);
        chk("edge_done_k", done_k, 3);
        chk("edge_hit", hit_o, 8'h08);
        chk("edge_tof3", tof(3), 16'd0);
        chk("edge_tof0_cleared", tof(0), 16'd0);
        after_done();
        cmp_i = '0;

        // Saturation with a stray start mid-ping
        no_rise();
        start_ping(16'd5, 16'd100, 16'hFFFF);
        run_ping(1, -1, 1000);
        chk("sat_done_seen", done_seen, 1'b1);
        chk("sat_done_t", done_t, 65535);
        chk("sat_done_age", done_age, 0);
        chk("sat_done_k", done_k, 65536);
        chk("sat_hit", hit_o, '0);
        after_done();
        chk("sat_no_restart", mclear_o, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sonar_ping_sequencer.md
Name: sonar_ping_sequencer

Overview:
- Sequences one sonar ping across all SonarOnChip receive channels: pulses mclear, gates the transmit burst, masks a blanking window, then measures per-channel time-of-flight.
- Time of flight is measured as the number of ce_pcm ticks until each channel's cmp first asserts.
- Sits between the wishbone register file (start/abort/config/results) and the channel array plus pcm_clk tick.
- Raises done when every channel has hit or the listen window times out.

Parameters:
- N_CH, 8, number of receive channels (width of cmp_i and hit_o).
- TW, 16, width of the tick timer and of each time-of-flight value.
- CLR_CYC, 4, number of wb_clk_i cycles mclear_o is held high (range 1..15).

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle ping request; ignored while busy_o=1.
- abort_i  in  1  one-cycle abort; wins over start_i.
- ce_pcm  in  1  one-cycle time-base tick from pcm_clk.
- tx_len_i  in  TW  transmit burst length, in ticks.
- blank_i  in  TW  end of blanking window, as an absolute tick count.
- timeout_i  in  TW  end of listen window, as an absolute tick count.
- cmp_i  in  N_CH  per-channel detection levels.
- mclear_o  out  1  clear to the channels.
- tx_en_o  out  1  transducer drive gate.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle completion pulse.
- hit_o  out  N_CH  per-channel "detected" flags.
- tof_o  out  N_CH*TW  flattened timestamps; channel i occupies bits [i*TW +: TW].

Behaviour:
- Reset: state=IDLE; timer=0; all outputs 0; hit_o=0; tof_o=0; latched config=0.
- States: IDLE, CLEAR, TX, BLANK, LISTEN, DONE.
- IDLE:
  - start_i=1 and abort_i=0 -> CLEAR on the next edge.
  - tx_len_i, blank_i and timeout_i are latched on that same edge; later input changes have no effect on this ping.
- CLEAR:
  - mclear_o=1 for exactly CLR_CYC cycles.
  - On entry, hit_o and tof_o clear to 0 and timer clears to 0.
  - Then -> TX.
- Timer:
  - Increments on every ce_pcm while in TX, BLANK or LISTEN.
  - Saturates at 2^TW-1; never wraps.
  - Is not reset between TX, BLANK and LISTEN.
- TX:
  - tx_en_o=1.
  - Exit to BLANK when ce_pcm=1 and timer+1 >= tx_len.
  - tx_len=0: TX lasts exactly one cycle, and tx_en_o is high for that cycle.
- BLANK:
  - tx_en_o=0; cmp_i is ignored.
  - Exit to LISTEN when timer >= blank.
  - blank <= timer on entry: move to LISTEN on the next edge.
- LISTEN, per cycle, for each i with cmp_i[i]=1 and hit[i]=0:
  - hit[i] <= 1.
  - tof[i] <= timer as registered this cycle (pre-increment, even if ce_pcm=1).
  - cmp_i is level-sensitive. A level already high on the first LISTEN cycle is captured with the current timer value.
  - Later cmp_i activity on a channel that has hit does not change its tof or hit.
  - Any number of channels may capture in the same cycle.
- LISTEN exit: go to DONE when all N_CH hits are set (including bits set this cycle), or when timer >= timeout.
  - Captures made in the exit cycle are kept.
  - timeout <= blank: LISTEN lasts one cycle, and captures are still evaluated in that cycle.
- DONE:
  - done_o=1 for one cycle, then -> IDLE.
  - hit_o and tof_o hold until the next ping enters CLEAR.
- abort_i=1 in any non-IDLE state:
  - -> IDLE next edge; mclear_o and tx_en_o go low that same edge.
  - No done_o pulse; hit_o and tof_o keep their partial values.
  - abort_i in IDLE has no effect.
- start_i while busy_o=1 is ignored and is not queued.
- wb_rst_i mid-ping: all state and outputs return to reset values on the next edge, with no done_o pulse.
- Outputs are registered, so no combinational path runs from inputs to outputs.

Test Plan:
- Basic ping, ce_pcm every 4 cycles:
  - Setup: start at cycle 0; tx_len=3, blank=10, timeout=100; cmp[2] rises when timer=37, cmp[5] rises when timer=50.
  - Required: mclear_o high cycles 1-4; tx_en_o high for 3 ticks; tof[2]=37, tof[5]=50, hit_o=8'h24.
  - Required: done_o pulses one cycle after the first cycle with timer>=100.
- Blanking: cmp[0]=1 held from CLEAR onward, blank=20 -> tof[0]=20, hit[0]=1.
- All-hit early exit: all 8 cmp rise together at timer=15, timeout=1000 -> all tof=15, done_o on the next cycle, timer never reaches 16.
- Abort and restart:
  - abort_i during LISTEN at timer=30, with hit_o=8'h01 and tof[0]=12 -> IDLE next cycle, tx_en_o=0, no done_o, hit_o=8'h01 and tof[0]=12 retained.
  - A new start then clears both.
- Edge configuration: tx_len=0, blank=0, timeout=0 -> TX for 1 cycle, BLANK for 1 cycle, LISTEN for 1 cycle, done_o; cmp high in that cycle gives tof=0.
- Saturation and interference:
  - timeout=16'hFFFF, no hits -> timer saturates at FFFF, done_o fires, hit_o=0.
  - start_i pulsed mid-ping has no effect.
  - wb_rst_i in TX -> all outputs 0 on the next edge.
